// File: rtl/nios2_ocimem_arbiter.sv
// Arbiter that shares the OCI debug RAM between the JTAG debug slave command
// pulses and the CPU-side Avalon debug memory slave. The RAM is single port
// with a 1-cycle read latency. JTAG commands are latched, the JTAG address
// auto-increments, ties alternate between requesters, and JTAG read data is
// returned in MonDReg.
module nios2_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_JRD, S_AVRD} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_jaddr;
  logic [ADDR_W-1:0]   r_jop_addr;
  logic                r_jop_wr;
  logic [DATA_W-1:0]   r_jop_data;
  logic                r_jpend;
  logic [DATA_W-1:0]   r_mondreg;
  logic                r_overrun;
  logic                r_last_av;   // 1 = Avalon was granted most recently
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;

  logic                w_av_req;
  logic                w_gnt_j, w_gnt_av;
  logic                w_b_drop, w_b_take;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic                w_ram_wren;
  logic [ADDR_W-1:0]   w_one;

  assign w_one    = {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_av_req = av_read | av_write;

  // A JTAG op is dropped if one is already queued or a JTAG read is returning,
  // or if it collides with an address load (the load still wins).
  assign w_b_drop = take_action_ocimem_b &
                    (r_jpend | (r_state == S_JRD) | take_action_ocimem_a);
  assign w_b_take = take_action_ocimem_b & ~w_b_drop;

  // Grant selection, next state and RAM port drive.
  always_comb begin
    w_gnt_j     = 1'b0;
    w_gnt_av    = 1'b0;
    w_state_nxt = r_state;
    w_ram_addr  = r_ram_addr;
    w_ram_wdata = r_ram_wdata;
    w_ram_wren  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_jpend && w_av_req) begin
          w_gnt_j  = r_last_av;
          w_gnt_av = ~r_last_av;
        end else begin
          w_gnt_j  = r_jpend;
          w_gnt_av = w_av_req;
        end
        if (w_gnt_j) begin
          w_ram_addr  = r_jop_addr;
          w_ram_wdata = r_jop_data;
          w_ram_wren  = r_jop_wr;
          w_state_nxt = r_jop_wr ? S_IDLE : S_JRD;
        end else if (w_gnt_av) begin
          // read and write together counts as a write
          w_ram_addr  = av_address;
          w_ram_wdata = av_writedata;
          w_ram_wren  = av_write;
          w_state_nxt = av_write ? S_IDLE : S_AVRD;
        end
      end
      S_JRD:   w_state_nxt = S_IDLE;
      S_AVRD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Hold the last RAM address/data between grants and remember who won.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_last_av   <= 1'b1;
    end else if (w_gnt_j || w_gnt_av) begin
      r_ram_addr  <= w_ram_addr;
      r_ram_wdata <= w_ram_wdata;
      r_last_av   <= w_gnt_av;
    end
  end

  // JTAG command capture, address auto-increment, overrun flag and read return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jaddr    <= '0;
      r_jop_addr <= '0;
      r_jop_wr   <= 1'b0;
      r_jop_data <= '0;
      r_jpend    <= 1'b0;
      r_overrun  <= 1'b0;
      r_mondreg  <= '0;
    end else begin
      if (take_action_ocimem_a) r_jaddr <= jdo[ADDR_W+16:17];
      else if (w_b_take)        r_jaddr <= r_jaddr + w_one;

      if (w_b_take) begin
        r_jop_addr <= r_jaddr;
        r_jop_wr   <= jdo[37];
        r_jop_data <= jdo[36:5];
        r_jpend    <= 1'b1;
      end else if (w_gnt_j) begin
        r_jpend    <= 1'b0;
      end

      if (w_b_drop)                  r_overrun <= 1'b1;
      else if (take_action_ocimem_a) r_overrun <= 1'b0;

      if (r_state == S_JRD) r_mondreg <= ram_rdata;
    end
  end

  assign ram_address      = w_ram_addr;
  assign ram_wdata        = w_ram_wdata;
  assign ram_wren         = w_ram_wren;
  assign av_waitrequest   = w_av_req & ~((r_state == S_IDLE) & w_gnt_av);
  assign av_readdatavalid = (r_state == S_AVRD);
  assign av_readdata      = (r_state == S_AVRD) ? ram_rdata : '0;
  assign MonDReg          = r_mondreg;
  assign jtag_busy        = r_jpend | (r_state == S_JRD);
  assign jtag_overrun     = r_overrun;

endmodule
